multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the 5-bit-opcode CPU datapath. It shares one memory port between instruction fetch and data access.
- Steps every instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same control fields the datapath already consumes: RegWrite, DataSelector, MemRead/MemWrite, AddrSelector, ALUOperator, ALUSelector.
- It also adds PC/IR write enables and a memory request/ready handshake.
- Sits between the instruction register, the unified memory and the register file / ALU / MUXes.

---
 rtl/mc_pkg.sv | 54 +++++
 rtl/mc_opdecode.sv | 54 +++++
 rtl/multicycle_controller.sv | 153 +++++++++++++++
 tb/tb_multicycle_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared opcodes, states and control-field encodings for the multicycle controller
package mc_pkg;

  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_ADDI = 5'd2;
  localparam logic [4:0] OP_SUB  = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4;
  localparam logic [4:0] OP_ANDI = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ORI  = 5'd7;
  localparam logic [4:0] OP_XOR  = 5'd8;
  localparam logic [4:0] OP_XORI = 5'd9;
  localparam logic [4:0] OP_SLL  = 5'd10;
  localparam logic [4:0] OP_SLLI = 5'd11;
  localparam logic [4:0] OP_SRL  = 5'd12;
  localparam logic [4:0] OP_SRLI = 5'd13;
  localparam logic [4:0] OP_LUI  = 5'd14;
  localparam logic [4:0] OP_LW   = 5'd15;
  localparam logic [4:0] OP_SW   = 5'd16;
  localparam logic [4:0] OP_BLT  = 5'd17;
  localparam logic [4:0] OP_BEQ  = 5'd18;
  localparam logic [4:0] OP_JAL  = 5'd19;
  localparam logic [4:0] OP_JALR = 5'd20;

  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_IMM = 2'b01;
  localparam logic [1:0] DS_MEM = 2'b10;
  localparam logic [1:0] DS_PC4 = 2'b11;

  localparam logic [2:0] AS_PC4  = 3'b000;
  localparam logic [2:0] AS_BLT  = 3'b001;
  localparam logic [2:0] AS_BEQ  = 3'b010;
  localparam logic [2:0] AS_JAL  = 3'b011;
  localparam logic [2:0] AS_JALR = 3'b100;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  localparam logic SRC_IMM = 1'b0;
  localparam logic SRC_RS2 = 1'b1;

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LUI, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP, CL_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/mc_opdecode.sv
// rtl/mc_opdecode.sv - combinational opcode decoder: instruction class and datapath field values
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic [2:0] alu_op,
  output logic       alu_src,
  output logic [1:0] data_sel,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       illegal
);

  always_comb begin
    op_class = CL_ILLEGAL;
    alu_op   = ALU_PASS;
    alu_src  = SRC_IMM;
    data_sel = DS_ALU;
    case (opcode)
      OP_ADD:  begin op_class = CL_ALU; alu_op = ALU_ADD; alu_src = SRC_RS2; end
      OP_ADDI: begin op_class = CL_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin op_class = CL_ALU; alu_op = ALU_SUB; alu_src = SRC_RS2; end
      OP_AND:  begin op_class = CL_ALU; alu_op = ALU_AND; alu_src = SRC_RS2; end
      OP_ANDI: begin op_class = CL_ALU; alu_op = ALU_AND; end
      OP_OR:   begin op_class = CL_ALU; alu_op = ALU_OR;  alu_src = SRC_RS2; end
      OP_ORI:  begin op_class = CL_ALU; alu_op = ALU_OR; end
      OP_XOR:  begin op_class = CL_ALU; alu_op = ALU_XOR; alu_src = SRC_RS2; end
      OP_XORI: begin op_class = CL_ALU; alu_op = ALU_XOR; end
      OP_SLL:  begin op_class = CL_ALU; alu_op = ALU_SLL; alu_src = SRC_RS2; end
      OP_SLLI: begin op_class = CL_ALU; alu_op = ALU_SLL; end
      OP_SRL:  begin op_class = CL_ALU; alu_op = ALU_SRL; alu_src = SRC_RS2; end
      OP_SRLI: begin op_class = CL_ALU; alu_op = ALU_SRL; end
      OP_LUI:  begin op_class = CL_LUI; data_sel = DS_IMM; end
      // loads and stores use the ALU to form base + offset
      OP_LW:   begin op_class = CL_LOAD; alu_op = ALU_ADD; data_sel = DS_MEM; end
      OP_SW:   begin op_class = CL_STORE; alu_op = ALU_ADD; end
      OP_BLT:  begin op_class = CL_BRANCH; alu_op = ALU_SUB; alu_src = SRC_RS2; end
      OP_BEQ:  begin op_class = CL_BRANCH; alu_op = ALU_SUB; alu_src = SRC_RS2; end
      OP_JAL:  begin op_class = CL_JUMP; data_sel = DS_PC4; end
      OP_JALR: begin op_class = CL_JUMP; alu_op = ALU_ADD; data_sel = DS_PC4; end
      default: op_class = CL_ILLEGAL;
    endcase
  end

  assign is_load   = (op_class == CL_LOAD);
  assign is_store  = (op_class == CL_STORE);
  assign is_branch = (op_class == CL_BRANCH);
  assign is_jump   = (op_class == CL_JUMP);
  assign illegal   = (op_class == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [4:0]       opcode_in,
  input  logic             lt_flag,
  input  logic             eq_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       data_sel,
  output logic [2:0]       addr_sel,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             busy,
  output logic             trap,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt
);

  state_t     state, state_next;
  logic [4:0] opcode_q;

  op_class_t  dec_class;
  logic [2:0] dec_alu_op;
  logic       dec_alu_src;
  logic [1:0] dec_data_sel;
  logic       dec_load, dec_store, dec_branch, dec_jump, dec_illegal;

  mc_opdecode u_dec (
    .opcode    (opcode_q),
    .op_class  (dec_class),
    .alu_op    (dec_alu_op),
    .alu_src   (dec_alu_src),
    .data_sel  (dec_data_sel),
    .is_load   (dec_load),
    .is_store  (dec_store),
    .is_branch (dec_branch),
    .is_jump   (dec_jump),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      opcode_q    <= '0;
      retired_cnt <= '0;
    end else begin
      state <= state_next;
      if (ir_write) opcode_q <= opcode_in;
      if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // ir_write / pc_write / retire in FETCH and MEM mark the completing beat of the handshake
  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    mem_is_data = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    data_sel    = DS_ALU;
    addr_sel    = AS_PC4;
    alu_op      = ALU_PASS;
    alu_src     = SRC_IMM;
    busy        = 1'b0;
    trap        = 1'b0;
    retire      = 1'b0;
    case (state)
      IDLE: begin
        if (run_en) state_next = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        busy = 1'b1;
        if (dec_illegal)            state_next = TRAP;
        else if (dec_class == CL_LUI) state_next = WB;
        else                        state_next = EXEC;
      end
      EXEC: begin
        busy    = 1'b1;
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        if (dec_branch) begin
          pc_write = 1'b1;
          retire   = 1'b1;
          if (opcode_q == OP_BLT) addr_sel = lt_flag ? AS_BLT : AS_PC4;
          else                    addr_sel = eq_flag ? AS_BEQ : AS_PC4;
          state_next = run_en ? FETCH : IDLE;
        end else if (dec_load || dec_store) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        busy        = 1'b1;
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        mem_read    = dec_load;
        mem_write   = dec_store;
        alu_op      = ALU_ADD;
        alu_src     = SRC_IMM;
        if (mem_ready) begin
          if (dec_load) begin
            state_next = WB;
          end else begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = run_en ? FETCH : IDLE;
          end
        end
      end
      WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        data_sel  = dec_data_sel;
        alu_op    = dec_alu_op;
        alu_src   = dec_alu_src;
        if (dec_jump) addr_sel = (opcode_q == OP_JALR) ? AS_JALR : AS_JAL;
        state_next = run_en ? FETCH : IDLE;
      end
      TRAP: begin
        trap = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed and randomized bench with an instruction-phase reference model
module tb_multicycle_controller;

  localparam int CW = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_is_data;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] data_sel;
    logic [2:0] addr_sel;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       busy;
    logic       trap;
    logic       retire;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n, run_en, lt_flag, eq_flag, mem_ready;
  logic [4:0] opcode_in;
  logic mem_req, mem_is_data, mem_read, mem_write, ir_write, pc_write, reg_write;
  logic [1:0] data_sel;
  logic [2:0] addr_sel, alu_op;
  logic alu_src, busy, trap, retire;
  logic [CW-1:0] retired_cnt;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en), .opcode_in(opcode_in),
    .lt_flag(lt_flag), .eq_flag(eq_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_is_data(mem_is_data), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .data_sel(data_sel), .addr_sel(addr_sel),
    .alu_op(alu_op), .alu_src(alu_src), .busy(busy), .trap(trap),
    .retire(retire), .retired_cnt(retired_cnt)
  );

  outs_t cur;
  assign cur = {mem_req, mem_is_data, mem_read, mem_write, ir_write, pc_write, reg_write,
                data_sel, addr_sel, alu_op, alu_src, busy, trap, retire};

  int errors = 0;
  int checks = 0;

  // model: queue of remaining phases of the current instruction (empty = idle)
  byte           plan[$];
  logic [4:0]    m_opc;
  logic [CW-1:0] m_cnt;
  bit            m_valid = 1'b0;
  outs_t         last;
  byte           last_ph;
  logic [CW-1:0] last_cnt;
  logic [2:0]    alu_op_tab [32];
  logic          alu_src_tab [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic string phases_for(input logic [4:0] op);
    if (op >= 5'd1 && op <= 5'd13) return "DEW";
    case (op)
      5'd14:        return "DW";
      5'd15:        return "DEMW";
      5'd16:        return "DEM";
      5'd17, 5'd18: return "DE";
      5'd19, 5'd20: return "DEW";
      default:      return "DT";
    endcase
  endfunction

  function automatic outs_t expect_outs(input byte ph, input bit rdy, input bit lt, input bit eq,
                                        input logic [4:0] op, input bit final_phase);
    outs_t o;
    bit done, ret;
    o = '0;
    done = (ph == "F" || ph == "M") ? rdy : (ph == "D" || ph == "E" || ph == "W");
    ret  = done && final_phase && (ph == "E" || ph == "M" || ph == "W");
    o.busy        = !(ph == "I" || ph == "T");
    o.trap        = (ph == "T");
    o.mem_req     = (ph == "F" || ph == "M");
    o.mem_is_data = (ph == "M");
    o.mem_read    = (ph == "F") || (ph == "M" && op == 5'd15);
    o.mem_write   = (ph == "M" && op == 5'd16);
    o.ir_write    = (ph == "F") && rdy;
    if (ph == "E" || ph == "M" || ph == "W") begin
      o.alu_op  = alu_op_tab[op];
      o.alu_src = alu_src_tab[op];
    end
    o.reg_write = (ph == "W");
    if (ph == "W")
      o.data_sel = (op == 5'd14) ? 2'd1 : (op == 5'd15) ? 2'd2 : (op >= 5'd19) ? 2'd3 : 2'd0;
    o.retire   = ret;
    o.pc_write = ret;
    if (ret) begin
      if (op == 5'd19)            o.addr_sel = 3'd3;
      else if (op == 5'd20)       o.addr_sel = 3'd4;
      else if (op == 5'd17 && lt) o.addr_sel = 3'd1;
      else if (op == 5'd18 && eq) o.addr_sel = 3'd2;
    end
    return o;
  endfunction

  task automatic step(input bit r, input bit run, input bit rdy, input bit lt, input bit eq,
                      input logic [4:0] opc);
    byte ph;
    bit final_phase, done;
    outs_t e;
    string s;
    rst_n = r; run_en = run; mem_ready = rdy; lt_flag = lt; eq_flag = eq; opcode_in = opc;
    @(negedge clk);
    ph = (plan.size() > 0) ? plan[0] : "I";
    final_phase = (plan.size() == 1);
    last = cur; last_ph = ph; last_cnt = retired_cnt;
    if (m_valid) begin
      e = expect_outs(ph, rdy, lt, eq, m_opc, final_phase);
      chk("outputs", 32'(cur), 32'(e));
      chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
    end
    if (!r) begin
      plan.delete(); m_opc = '0; m_cnt = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (ph == "I") begin
        if (run) plan.push_back("F");
      end else if (ph != "T") begin
        done = (ph == "F" || ph == "M") ? rdy : 1'b1;
        if (done) begin
          void'(plan.pop_front());
          if (ph == "F") begin
            m_opc = opc;
            s = phases_for(opc);
            for (int i = 0; i < s.len(); i++) plan.push_back(s[i]);
          end else if (plan.size() == 0) begin
            m_cnt++;
            if (run) plan.push_back("F");
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [4:0] opc, input bit lt, input bit eq, input int wf,
                           input int wm, input bit run_after, output int cycles,
                           output outs_t ce, output outs_t cm, output outs_t cw);
    int n;
    bit rdy, got;
    n = 0; got = 1'b0; ce = '0; cm = '0; cw = '0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, opc);
    while (n < 40 && !got) begin
      rdy = 1'b1;
      if (plan.size() > 0 && plan[0] == "F" && wf > 0) begin rdy = 1'b0; wf--; end
      if (plan.size() > 0 && plan[0] == "M" && wm > 0) begin rdy = 1'b0; wm--; end
      step(1'b1, run_after, rdy, lt, eq, opc);
      n++;
      if (last_ph == "E") ce = last;
      if (last_ph == "M") cm = last;
      if (last_ph == "W") cw = last;
      got = last.retire;
    end
    cycles = n;
    chk("retire_seen", 32'(got), 32'd1);
  endtask

  task automatic trap_case(input logic [4:0] opc);
    outs_t tr;
    tr = '0;
    tr.trap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, opc);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, opc);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, opc);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 5'($urandom));
      chk("trap_outputs", 32'(last), 32'(tr));
      chk("trap_cnt", 32'(last_cnt), 32'd1);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    int n, tcount;
    outs_t ce, cm, cw;
    bit r;
    logic [4:0] opc;
    for (int i = 0; i < 32; i++) begin alu_op_tab[i] = 3'd0; alu_src_tab[i] = 1'b0; end
    alu_op_tab[1]  = 3'd1; alu_src_tab[1]  = 1'b1;  alu_op_tab[2]  = 3'd1;
    alu_op_tab[3]  = 3'd2; alu_src_tab[3]  = 1'b1;
    alu_op_tab[4]  = 3'd3; alu_src_tab[4]  = 1'b1;  alu_op_tab[5]  = 3'd3;
    alu_op_tab[6]  = 3'd4; alu_src_tab[6]  = 1'b1;  alu_op_tab[7]  = 3'd4;
    alu_op_tab[8]  = 3'd5; alu_src_tab[8]  = 1'b1;  alu_op_tab[9]  = 3'd5;
    alu_op_tab[10] = 3'd6; alu_src_tab[10] = 1'b1;  alu_op_tab[11] = 3'd6;
    alu_op_tab[12] = 3'd7; alu_src_tab[12] = 1'b1;  alu_op_tab[13] = 3'd7;
    alu_op_tab[15] = 3'd1; alu_op_tab[16] = 3'd1;
    alu_op_tab[17] = 3'd2; alu_src_tab[17] = 1'b1;
    alu_op_tab[18] = 3'd2; alu_src_tab[18] = 1'b1;
    alu_op_tab[20] = 3'd1;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    chk("reset_outputs", 32'(last), 32'd0);
    chk("reset_cnt", 32'(last_cnt), 32'd0);

    run_instr(5'd1, 1'b0, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    chk("add_cycles", 32'(n), 32'd4);
    chk("add_exec_alu", 32'({ce.alu_op, ce.alu_src}), 32'b0011);
    chk("add_wb", 32'({cw.reg_write, cw.pc_write, cw.data_sel, cw.addr_sel}), 32'b11_00_000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    chk("add_cnt", 32'(last_cnt), 32'd1);
    chk("add_idle_busy", 32'(last.busy), 32'd0);

    run_instr(5'd15, 1'b0, 1'b0, 0, 3, 1'b0, n, ce, cm, cw);
    chk("lw_cycles", 32'(n), 32'd8);
    chk("lw_mem", 32'({cm.mem_req, cm.mem_is_data, cm.mem_read, cm.mem_write}), 32'b1110);
    chk("lw_wb_data_sel", 32'(cw.data_sel), 32'd2);

    run_instr(5'd18, 1'b0, 1'b1, 0, 0, 1'b0, n, ce, cm, cw);
    chk("beq_cycles", 32'(n), 32'd3);
    chk("beq_taken", 32'({ce.pc_write, ce.retire, ce.reg_write, ce.addr_sel}), 32'b110_010);
    run_instr(5'd18, 1'b1, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    chk("beq_not_taken", 32'(ce.addr_sel), 32'd0);
    run_instr(5'd17, 1'b1, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    chk("blt_taken", 32'(ce.addr_sel), 32'd1);

    run_instr(5'd20, 1'b0, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    chk("jalr_cycles", 32'(n), 32'd4);
    chk("jalr_exec_alu", 32'({ce.alu_op, ce.alu_src}), 32'b0010);
    chk("jalr_wb", 32'({cw.reg_write, cw.data_sel, cw.addr_sel}), 32'b1_11_100);

    run_instr(5'd14, 1'b0, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    chk("lui_cycles", 32'(n), 32'd3);
    chk("lui_data_sel", 32'(cw.data_sel), 32'd1);

    run_instr(5'd16, 1'b0, 1'b0, 1, 2, 1'b0, n, ce, cm, cw);
    chk("sw_cycles", 32'(n), 32'd7);
    chk("sw_mem", 32'({cm.mem_write, cm.mem_read, cm.pc_write, cm.addr_sel}), 32'b101_000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
    chk("sw_then_idle", 32'(last.busy), 32'd0);
    chk("cnt_after_directed", 32'(last_cnt), 32'd8);

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
    chk("fetch_wait_req", 32'(last.mem_req), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
    chk("reset_drops_req", 32'({last.mem_req, last.busy}), 32'd0);
    chk("reset_clears_cnt", 32'(last_cnt), 32'd0);

    run_instr(5'd3, 1'b0, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    trap_case(5'd0);
    run_instr(5'd9, 1'b0, 1'b0, 0, 0, 1'b0, n, ce, cm, cw);
    trap_case(5'd25);

    tcount = 0;
    for (int i = 0; i < 4000; i++) begin
      if (plan.size() > 0 && plan[0] == "T") tcount++; else tcount = 0;
      r = (tcount <= 4) && ($urandom_range(0, 299) != 0);
      case ($urandom_range(0, 49))
        0:       opc = 5'(21 + $urandom_range(0, 10));
        1:       opc = 5'd0;
        default: opc = 5'($urandom_range(1, 20));
      endcase
      step(r, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), opc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
